step_button_ctrl: RTL

- Conditions two raw push-buttons (step-up, step-down) into the control inputs of the prescaled up/down step counter downstream: a one-cycle `en` pulse and a direction level `up`.
- Synchronizes and debounces each button on a slow sample strobe.
- Arbitrates the two buttons, then generates a single step per press plus auto-repeat while a button is held.
- Sits between the board button pins and the step counter's `en`/`up` inputs.

---
 rtl/step_button_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/step_button_ctrl.sv
// Push-button front end for the up/down step counter: synchronize, debounce on a slow
// strobe, arbitrate the two buttons, and emit one step per press plus auto-repeat.
module step_button_ctrl #(
   parameter int SAMP_DIV   = 100000,
   parameter int DB_N       = 4,
   parameter int REP_DELAY  = 50,
   parameter int REP_PERIOD = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up_raw,
   input  logic btn_dn_raw,
   output logic en,
   output logic up,
   output logic db_up,
   output logic db_dn,
   output logic busy
);

   localparam int STRB_W  = $clog2(SAMP_DIV);
   localparam int DB_W    = $clog2(DB_N);
   localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   localparam logic [STRB_W-1:0] STRB_LAST  = STRB_W'(SAMP_DIV - 1);
   localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DB_N - 1);
   localparam logic [REP_W-1:0]  REP_TOP    = REP_W'(REP_MAX);
   localparam logic [REP_W-1:0]  DELAY_HIT  = REP_W'(REP_DELAY);
   localparam logic [REP_W-1:0]  PERIOD_HIT = REP_W'(REP_PERIOD);
   localparam bit                REP_EN     = (REP_DELAY != 0);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

   // Per-button vectors: bit 0 is the step-up button, bit 1 the step-down button.
   logic [1:0]             sync1_q, sync1_d;
   logic [1:0]             sync2_q, sync2_d;
   logic [STRB_W-1:0]      strb_cnt_q, strb_cnt_d;
   logic                   strb;
   logic [1:0]             db_q, db_d;
   logic [1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;

   state_t                 state_q, state_d;
   logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
   logic [REP_W-1:0]       rep_nxt;
   logic                   dir_q, dir_d;
   logic                   act, oth, rep_hit, step;

   logic                   en_q, en_d;
   logic                   up_q, up_d;
   logic                   busy_q, busy_d;

   // ---------------------------------------------------------------- synchronizer
   always_comb begin
      sync1_d = {btn_dn_raw, btn_up_raw};
      sync2_d = sync1_q;
   end

   // ---------------------------------------------------------------- sample strobe
   always_comb begin
      strb       = (strb_cnt_q == STRB_LAST);
      strb_cnt_d = strb ? '0 : strb_cnt_q + 1'b1;
   end

   // ---------------------------------------------------------------- debounce
   // The count holds the number of earlier consecutive disagreeing samples, so the
   // level flips on the DB_N-th one and the counter never exceeds DB_N-1.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it
      // unassigned and no latch is inferred.
      db_d     = db_q;
      db_cnt_d = db_cnt_q;
      if (strb) begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
               if (db_cnt_q[i] == DB_LAST) begin
                  db_d[i]     = ~db_q[i];
                  db_cnt_d[i] = '0;
               end else begin
                  db_cnt_d[i] = db_cnt_q[i] + 1'b1;
               end
            end else begin
               db_cnt_d[i] = '0;
            end
         end
      end
   end

   // ---------------------------------------------------------------- FSM next state
   // The FSM looks at the next debounced levels so a release and a repeat strobe
   // landing together resolve in favour of the release.
   always_comb begin
      act     = dir_q ? db_d[0] : db_d[1];
      oth     = dir_q ? db_d[1] : db_d[0];
      rep_nxt = (rep_cnt_q < REP_TOP) ? rep_cnt_q + 1'b1 : rep_cnt_q;
      rep_hit = (state_q == HOLD) ? (REP_EN && (rep_nxt == DELAY_HIT))
                                  : (rep_nxt == PERIOD_HIT);
   end

   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      dir_d     = dir_q;
      step      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (db_d[0] && db_d[1]) begin
               state_d = LOCK;
            end else if (db_d[0] || db_d[1]) begin
               step      = 1'b1;
               dir_d     = db_d[0];
               rep_cnt_d = '0;
               state_d   = HOLD;
            end
         end
         HOLD, REPEAT: begin
            if (!act) begin
               state_d = IDLE;
            end else if (oth) begin
               state_d = LOCK;
            end else if (strb) begin
               if (rep_hit) begin
                  step      = 1'b1;
                  rep_cnt_d = '0;
                  state_d   = REPEAT;
               end else begin
                  rep_cnt_d = rep_nxt;
               end
            end
         end
         LOCK: begin
            if (!db_d[0] && !db_d[1]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM outputs
   always_comb begin
      en_d   = step;
      up_d   = step ? dir_d : up_q;
      busy_d = (state_d != IDLE);
   end

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // independent of statement order in this block.
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         strb_cnt_q <= '0;
         db_q       <= '0;
         db_cnt_q   <= '0;
         state_q    <= IDLE;
         rep_cnt_q  <= '0;
         dir_q      <= 1'b0;
         en_q       <= 1'b0;
         up_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         strb_cnt_q <= strb_cnt_d;
         db_q       <= db_d;
         db_cnt_q   <= db_cnt_d;
         state_q    <= state_d;
         rep_cnt_q  <= rep_cnt_d;
         dir_q      <= dir_d;
         en_q       <= en_d;
         up_q       <= up_d;
         busy_q     <= busy_d;
      end
   end

   assign en    = en_q;
   assign up    = up_q;
   assign db_up = db_q[0];
   assign db_dn = db_q[1];
   assign busy  = busy_q;

endmodule
